// File: rtl/accumulate.sv
// accumulate: sums N signed 2*W-bit products, floors the sum by FRAC bits,
// saturates it to W bits and offers it downstream with a valid/ready handshake.
// arg_ready and res_valid are registered state flags with no combinational path
// from any input.
module accumulate #(
    parameter int W    = 16,
    parameter int N    = 4,
    parameter int FRAC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arg_valid,
    input  logic [2*W-1:0]   arg_data,
    output logic             arg_ready,
    output logic             res_valid,
    output logic [W-1:0]     res_data,
    input  logic             res_ready
);

    // Accumulator is wide enough that N full-scale products cannot overflow.
    localparam int ACCW = 2*W + $clog2(N) + 1;
    localparam int CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Saturation limits, sign-extended to the accumulator width.
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

    state_t                 state;
    logic signed [ACCW-1:0] acc;
    logic [CW-1:0]          cnt;

    logic signed [ACCW-1:0] sum_next;
    logic signed [ACCW-1:0] shifted;
    logic [W-1:0]           sat_value;
    logic                   arg_fire;
    logic                   res_fire;

    assign arg_fire = arg_valid && arg_ready;
    assign res_fire = res_valid && res_ready;

    // Running sum including the current product, then floor-shift and clamp.
    always_comb begin
        sum_next  = acc + {{(ACCW-2*W){arg_data[2*W-1]}}, arg_data};
        shifted   = sum_next >>> FRAC;
        sat_value = shifted[W-1:0];
        if (shifted > SAT_MAX) begin
            sat_value = SAT_MAX[W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_value = SAT_MIN[W-1:0];
        end
    end

    // Two-state controller with registered handshake flags and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            res_data  <= '0;
            arg_ready <= 1'b1;
            res_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (arg_fire) begin
                        acc <= sum_next;
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            res_data  <= sat_value;
                            state     <= RESULT;
                            arg_ready <= 1'b0;
                            res_valid <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                RESULT: begin
                    if (res_fire) begin
                        acc       <= '0;
                        state     <= ACCUM;
                        arg_ready <= 1'b1;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    arg_ready <= 1'b1;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accumulate.sv
// Bench for accumulate (W=16, N=4, FRAC=8): directed vectors with literal
// expectations plus a transaction-level model checked every cycle.
module tb_accumulate;

    localparam int W    = 16;
    localparam int N    = 4;
    localparam int FRAC = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arg_valid = 1'b0;
    logic [31:0]   arg_data = '0;
    logic          arg_ready;
    logic          res_valid;
    logic [15:0]   res_data;
    logic          res_ready = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    accumulate #(.W(W), .N(N), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .arg_valid (arg_valid),
        .arg_data  (arg_data),
        .arg_ready (arg_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    longint m_sum      = 0;
    int     m_terms    = 0;
    bit     m_pending  = 0;
    logic [15:0] m_res = '0;
    int     m_delivered = 0;
    bit     chk_en     = 0;

    function automatic logic [15:0] expect_result(input longint s);
        longint d, q;
        d = longint'(1) << FRAC;
        q = (s - (((s % d) + d) % d)) / d;   // floor division
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_sum = 0; m_terms = 0; m_pending = 0;
            chk_en = 1;
        end else if (m_pending) begin
            if (res_ready) begin
                m_pending = 0;
                m_delivered++;
            end
        end else if (arg_valid) begin
            m_sum += longint'($signed(arg_data));
            m_terms++;
            if (m_terms == N) begin
                m_res = expect_result(m_sum);
                m_pending = 1;
                m_sum = 0;
                m_terms = 0;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("arg_ready", {31'd0, arg_ready}, {31'd0, !m_pending});
            check("res_valid", {31'd0, res_valid}, {31'd0, m_pending});
            if (m_pending) check("res_data", {16'd0, res_data}, {16'd0, m_res});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [31:0] p);
        int t = 0;
        while (!arg_ready && t < 1000) begin tick(); t++; end
        if (t >= 1000) check("send_timeout", 32'd1, 32'd0);
        arg_valid = 1'b1; arg_data = p;
        tick();
        arg_valid = 1'b0; arg_data = $urandom;
    endtask

    task automatic send4(input logic [31:0] p);
        for (int i = 0; i < 4; i++) send(p);
    endtask

    task automatic recv(input string name, input logic [15:0] exp);
        int t = 0;
        while (!res_valid && t < 1000) begin tick(); t++; end
        if (t >= 1000) check({name, "_timeout"}, 32'd1, 32'd0);
        check(name, {16'd0, res_data}, {16'd0, exp});
        check({name, "_model"}, {16'd0, m_res}, {16'd0, exp});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic random_run(input int groups);
        int target = m_delivered + groups;
        int cyc = 0;
        logic [15:0] a, b;
        while (m_delivered < target && cyc < 1000000) begin
            a = 16'($urandom); b = 16'($urandom);
            arg_valid = ($urandom_range(0, 3) != 0);
            arg_data  = 32'($signed(a) * $signed(b));
            res_ready = ($urandom_range(0, 2) != 0);
            tick();
            cyc++;
        end
        if (cyc >= 1000000) check("random_timeout", 32'd1, 32'd0);
        arg_valid = 1'b0; res_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] held;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_arg_ready", {31'd0, arg_ready}, 32'd1);
        check("reset_res_valid", {31'd0, res_valid}, 32'd0);
        check("reset_res_data",  {16'd0, res_data},  32'd0);

        // Basic sum, result visible right after the 4th accept.
        send4(32'h0001_0000);
        check("basic_latency", {31'd0, res_valid}, 32'd1);
        recv("basic", 16'h0400);

        send4(32'hFFFF_0000); recv("neg", 16'hFC00);
        send4(32'h0000_0001); recv("floor_pos", 16'h0000);
        send4(32'hFFFF_FFFF); recv("floor_neg", 16'hFFFF);
        send4(32'h7FFF_FFFF); recv("sat_pos", 16'h7FFF);
        send4(32'h8000_0000); recv("sat_neg", 16'h8000);

        // Backpressure: offered products must not be consumed while held.
        send4(32'h0002_0000);
        held = res_data;
        arg_valid = 1'b1; arg_data = 32'h7FFF_0000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_res_valid", {31'd0, res_valid}, 32'd1);
            check("bp_arg_ready", {31'd0, arg_ready}, 32'd0);
            check("bp_stable", {16'd0, res_data}, {16'd0, held});
        end
        check("bp_value", {16'd0, held}, 32'h0000_0800);
        arg_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_release", {31'd0, arg_ready}, 32'd1);
        send4(32'h0001_0000); recv("after_bp", 16'h0400);

        // Reset mid-accumulation discards partial sum.
        send(32'h0005_0000); send(32'h0005_0000);
        rst = 1'b1; tick(); rst = 1'b0;
        send4(32'h0001_0000); recv("after_rst", 16'h0400);

        // Reset while a result is pending, with res_ready high.
        send4(32'h0003_0000);
        rst = 1'b1; res_ready = 1'b1; tick(); rst = 1'b0; res_ready = 1'b0;
        check("rst_in_result", {31'd0, res_valid}, 32'd0);

        // Random groups, a mid-run reset, then more random groups.
        random_run(4);
        send(32'h1234_5678);
        rst = 1'b1; tick(); rst = 1'b0;
        random_run(4);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
